// File: rtl/tgen_pkg.sv
// Shared types and helpers for the instruction-fetch traffic generator.
package tgen_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'd0,
    MODE_STRIDE = 2'd1,
    MODE_RAND   = 2'd2,
    MODE_RSVD   = 2'd3
  } tgen_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tgen_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Number of address bits below one fetch word (forced to zero on the bus).
  function automatic int byte_off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/tgen_addr_fifo.sv
// In-order FIFO holding the addresses of granted-but-unanswered fetches.
// Read data is first-word fall-through; push and pop may coincide.
module tgen_addr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CAP);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array: data only, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/tgen_fetch_multi.sv
// Instruction-fetch traffic generator: issues req/gnt fetches in SEQ, STRIDE
// or LFSR-random address order inside a masked window, keeps up to
// MAX_OUTSTANDING requests in flight and checks each in-order response
// against its own address.
module tgen_fetch_multi
  import tgen_pkg::*;
#(
  parameter int FETCH_ADDR_WIDTH = 32,
  parameter int FETCH_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic [FETCH_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [FETCH_ADDR_WIDTH-1:0] window_mask_i,
  input  logic [FETCH_ADDR_WIDTH-1:0] stride_i,
  input  logic [31:0]                 seed_i,
  input  logic [CNT_WIDTH-1:0]        n_trans_i,
  input  logic                        check_en_i,
  output logic                        fetch_req_o,
  output logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                        fetch_gnt_i,
  input  logic                        fetch_rvalid_i,
  input  logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [CNT_WIDTH-1:0]        issued_o,
  output logic [CNT_WIDTH-1:0]        retired_o,
  output logic [CNT_WIDTH-1:0]        err_cnt_o,
  output logic [FETCH_ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                        proto_err_o
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  localparam int OFF_BITS = byte_off_bits(FETCH_DATA_WIDTH);
  localparam int OW       = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [FETCH_ADDR_WIDTH-1:0] LOW_MASK =
    FETCH_ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [FETCH_ADDR_WIDTH-1:0] SEQ_STEP = FETCH_ADDR_WIDTH'(FETCH_DATA_WIDTH / 8);
  localparam logic [OW-1:0]               OUT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE  = CNT_WIDTH'(1);

  // Error counter increments stop at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]                  state;
  logic [1:0]                  mode_q;
  logic [FETCH_ADDR_WIDTH-1:0] base_q;
  logic [FETCH_ADDR_WIDTH-1:0] mask_q;
  logic [FETCH_ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]        n_trans_q;
  logic                        check_en_q;
  logic [FETCH_ADDR_WIDTH-1:0] offset_q;
  logic [31:0]                 lfsr_q;
  logic [31:0]                 lfsr_nxt;
  logic [OW-1:0]               out_cnt_q;
  logic [CNT_WIDTH-1:0]        issued_q;
  logic [CNT_WIDTH-1:0]        retired_q;
  logic [CNT_WIDTH-1:0]        err_cnt_q;
  logic [FETCH_ADDR_WIDTH-1:0] first_err_q;
  logic                        proto_err_q;

  logic                        start_ok;
  logic                        req;
  logic                        accept;
  logic                        last_grant;
  logic                        pop;
  logic                        mismatch;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [FETCH_ADDR_WIDTH-1:0] fifo_addr;
  logic [FETCH_DATA_WIDTH-1:0] expected;

  // Request depends on registered state only, never on gnt or rvalid.
  assign start_ok   = start_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign req        = (state == ST_RUN) && (out_cnt_q < OUT_MAX) && !fifo_full;
  assign accept     = req && fetch_gnt_i;
  assign last_grant = (issued_q == n_trans_q - CNT_ONE);
  assign pop        = fetch_rvalid_i && !fifo_empty;
  assign expected   = FETCH_DATA_WIDTH'(fifo_addr);
  assign mismatch   = check_en_q && (fetch_rdata_i != expected);
  assign lfsr_nxt   = lfsr_step(lfsr_q);

  assign fetch_req_o      = req;
  assign fetch_addr_o     = (base_q + (offset_q & mask_q)) & ~LOW_MASK;
  assign busy_o           = (state == ST_RUN) || (state == ST_DRAIN);
  assign done_o           = (state == ST_DONE);
  assign issued_o         = issued_q;
  assign retired_o        = retired_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign proto_err_o      = proto_err_q;

  tgen_addr_fifo #(
    .WIDTH (FETCH_ADDR_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .wdata (fetch_addr_o),
    .rdata (fifo_addr),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Control FSM, capturing the run configuration on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      base_q     <= '0;
      mask_q     <= '0;
      stride_q   <= '0;
      n_trans_q  <= '0;
      check_en_q <= 1'b0;
    end else if (start_ok) begin
      mode_q     <= mode_i;
      base_q     <= base_addr_i;
      mask_q     <= window_mask_i;
      stride_q   <= stride_i;
      n_trans_q  <= n_trans_i;
      check_en_q <= check_en_i;
      state      <= (n_trans_i == '0) ? ST_DONE : ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (accept && last_grant) state <= ST_DRAIN;
        ST_DRAIN: if (out_cnt_q == '0) state <= ST_DONE;
        default:  state <= state;
      endcase
    end
  end

  // Offset and LFSR advance only when a request is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      lfsr_q   <= 32'd1;
    end else if (start_ok) begin
      offset_q <= '0;
      lfsr_q   <= (seed_i == 32'd0) ? 32'd1 : seed_i;
    end else if (accept) begin
      case (mode_q)
        MODE_STRIDE: offset_q <= offset_q + stride_q;
        MODE_RAND: begin
          lfsr_q   <= lfsr_nxt;
          offset_q <= FETCH_ADDR_WIDTH'(lfsr_nxt);
        end
        default:     offset_q <= offset_q + SEQ_STEP;
      endcase
    end
  end

  // Transaction statistics and response checking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q    <= '0;
      retired_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      proto_err_q <= 1'b0;
    end else if (start_ok) begin
      issued_q    <= '0;
      retired_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) issued_q <= issued_q + CNT_ONE;
      if (pop) begin
        retired_q <= retired_q + CNT_ONE;
        if (mismatch) begin
          err_cnt_q <= sat_inc(err_cnt_q);
          if (err_cnt_q == '0) first_err_q <= fifo_addr;
        end
      end
      if (fetch_rvalid_i && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  // Outstanding count: a simultaneous grant and response cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   out_cnt_q <= out_cnt_q + OW'(1);
        2'b01:   out_cnt_q <= out_cnt_q - OW'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_tgen_fetch_multi.sv
// Bench for tgen_fetch_multi: an in-order responder backed by a memory that
// holds each word's own address, plus a reference address/response model.
module tb_tgen_fetch_multi;

  localparam int          MAXO = 4;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  mode_i;
  logic [31:0] base_addr_i, window_mask_i, stride_i, seed_i, n_trans_i;
  logic        check_en_i;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_gnt_i, fetch_rvalid_i;
  logic [31:0] fetch_rdata_i;
  logic        busy_o, done_o;
  logic [31:0] issued_o, retired_o, err_cnt_o, first_err_addr_o;
  logic        proto_err_o;

  always #5 clk = ~clk;

  tgen_fetch_multi #(
    .FETCH_ADDR_WIDTH (32),
    .FETCH_DATA_WIDTH (32),
    .MAX_OUTSTANDING  (MAXO),
    .CNT_WIDTH        (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .mode_i           (mode_i),
    .base_addr_i      (base_addr_i),
    .window_mask_i    (window_mask_i),
    .stride_i         (stride_i),
    .seed_i           (seed_i),
    .n_trans_i        (n_trans_i),
    .check_en_i       (check_en_i),
    .fetch_req_o      (fetch_req_o),
    .fetch_addr_o     (fetch_addr_o),
    .fetch_gnt_i      (fetch_gnt_i),
    .fetch_rvalid_i   (fetch_rvalid_i),
    .fetch_rdata_i    (fetch_rdata_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .issued_o         (issued_o),
    .retired_o        (retired_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o),
    .proto_err_o      (proto_err_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  logic [31:0] got_first[$];
  logic [31:0] pend[$];
  int          acc;
  int          resp;
  int          acc_at_hold;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Address list a run must produce, straight from the window/mode rules.
  function automatic void build_expected(input int mode, input logic [31:0] base, mask,
                                         stride, seed, input int n);
    logic [31:0] off;
    logic [31:0] lf;
    exp_q.delete();
    off = 32'd0;
    lf  = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back((base + (off & mask)) & ~32'h3);
      case (mode)
        1: off = off + stride;
        2: begin
          lf  = lf[0] ? ((lf >> 1) ^ POLY) : (lf >> 1);
          off = lf;
        end
        default: off = off + 32'd4;
      endcase
    end
  endfunction

  // One complete run: start, drive gnt/rvalid, follow the model, check stats.
  task automatic run(input string tag, input int mode, input logic [31:0] base, mask,
                     stride, seed, input int n, input bit chk_en, input int gnt_pct,
                     input int rv_pct, input int gnt_hold, input int rv_hold,
                     input int bad_idx);
    int          c;
    bit          done_seen;
    bit          prev_stall;
    bit          req_s;
    logic [31:0] addr_s;
    logic [31:0] prev_addr;
    int          err_exp;
    logic [31:0] ferr_exp;

    build_expected(mode, base, mask, stride, seed, n);
    got.delete();
    pend.delete();
    acc = 0;
    resp = 0;
    acc_at_hold = -1;
    @(negedge clk);
    mode_i = mode[1:0];
    base_addr_i = base;
    window_mask_i = mask;
    stride_i = stride;
    seed_i = seed;
    n_trans_i = n;
    check_en_i = chk_en;
    start_i = 1'b1;
    @(posedge clk);
    c = 0;
    done_seen = 1'b0;
    prev_stall = 1'b0;
    prev_addr = '0;
    while (!done_seen && c < 3000) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) done_seen = 1'b1;
      req_s  = fetch_req_o;
      addr_s = fetch_addr_o;
      check({tag, ".req"}, 64'(req_s), 64'((acc < n) && (acc - resp < MAXO)));
      if (req_s && acc < n) check({tag, ".addr"}, 64'(addr_s), 64'(exp_q[acc]));
      if (prev_stall && req_s) check({tag, ".stable"}, 64'(addr_s), 64'(prev_addr));
      if (c == rv_hold) acc_at_hold = acc;
      fetch_rvalid_i = 1'b0;
      fetch_rdata_i  = '0;
      if (pend.size() > 0 && c >= rv_hold && int'($urandom_range(99)) < rv_pct) begin
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = pend.pop_front();
        if (resp == bad_idx) fetch_rdata_i = fetch_rdata_i ^ 32'h1;
      end
      fetch_gnt_i = (c >= gnt_hold) && (int'($urandom_range(99)) < gnt_pct);
      prev_stall = req_s && !fetch_gnt_i;
      prev_addr  = addr_s;
      @(posedge clk);
      if (req_s && fetch_gnt_i) begin
        got.push_back(addr_s);
        pend.push_back(addr_s);
        acc++;
      end
      if (fetch_rvalid_i) resp++;
      c++;
    end
    fetch_gnt_i = 1'b0;
    fetch_rvalid_i = 1'b0;
    @(negedge clk);
    check({tag, ".finished"}, 64'(done_seen), 64'd1);
    check({tag, ".count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check({tag, ".seq"}, 64'(got[i]), 64'(exp_q[i]));
    err_exp  = (chk_en && bad_idx >= 0 && bad_idx < n) ? 1 : 0;
    ferr_exp = (err_exp == 1) ? exp_q[bad_idx] : 32'd0;
    check({tag, ".issued"}, 64'(issued_o), 64'(n));
    check({tag, ".retired"}, 64'(retired_o), 64'(n));
    check({tag, ".err_cnt"}, 64'(err_cnt_o), 64'(err_exp));
    check({tag, ".first_err"}, 64'(first_err_addr_o), 64'(ferr_exp));
    check({tag, ".proto"}, 64'(proto_err_o), 64'd0);
    check({tag, ".busy"}, 64'(busy_o), 64'd0);
    check({tag, ".done"}, 64'(done_o), 64'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    start_i = 1'b0;
    mode_i = '0;
    base_addr_i = '0;
    window_mask_i = '0;
    stride_i = '0;
    seed_i = '0;
    n_trans_i = '0;
    check_en_i = 1'b0;
    fetch_gnt_i = 1'b0;
    fetch_rvalid_i = 1'b0;
    fetch_rdata_i = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.req", 64'(fetch_req_o), 64'd0);
    check("rst.addr", 64'(fetch_addr_o), 64'd0);
    check("rst.busy", 64'(busy_o), 64'd0);
    check("rst.done", 64'(done_o), 64'd0);
    check("rst.issued", 64'(issued_o), 64'd0);
    check("rst.proto", 64'(proto_err_o), 64'd0);
    rst_n = 1'b1;

    // Sequential run with an always-ready memory
    run("seq", 0, 32'h1000, 32'hFFF, 32'h0, 32'h1, 8, 1'b1, 100, 100, 0, 0, -1);
    check("seq.first", 64'(got.size() > 0 ? got[0] : 32'hDEAD), 64'h1000);
    check("seq.last", 64'(got.size() > 7 ? got[7] : 32'hDEAD), 64'h101C);

    // Responses withheld: issue must stall at the in-flight limit
    run("bp", 0, 32'h4000, 32'hFFFF, 32'h0, 32'h1, 12, 1'b1, 100, 100, 0, 20, -1);
    check("bp.stall_at", 64'(acc_at_hold), 64'(MAXO));

    // Stride with a delayed grant
    run("stride", 1, 32'h0, 32'hFF, 32'h40, 32'h1, 6, 1'b1, 100, 100, 5, 0, -1);
    check("stride.a4", 64'(got.size() > 4 ? got[4] : 32'hDEAD), 64'h00);
    check("stride.a5", 64'(got.size() > 5 ? got[5] : 32'hDEAD), 64'h40);

    // Random mode from seed 0, run twice under random handshakes
    run("rand1", 2, 32'h0, 32'hFFC, 32'h0, 32'h0, 16, 1'b1, 60, 60, 0, 0, -1);
    got_first = got;
    run("rand2", 2, 32'h0, 32'hFFC, 32'h0, 32'h0, 16, 1'b1, 60, 60, 0, 0, -1);
    check("rand.rerun_len", 64'(got.size()), 64'(got_first.size()));
    for (int i = 0; i < got.size() && i < got_first.size(); i++)
      check("rand.rerun", 64'(got[i]), 64'(got_first[i]));

    // Corrupted response on transaction 3, checked and unchecked
    run("bad_chk", 0, 32'h8000, 32'hFFF, 32'h0, 32'h1, 8, 1'b1, 100, 100, 0, 0, 3);
    run("bad_nochk", 0, 32'h8000, 32'hFFF, 32'h0, 32'h1, 8, 1'b0, 100, 100, 0, 0, 3);

    // Randomised configurations
    for (int k = 0; k < 4; k++) begin
      logic [31:0] msk;
      case ($urandom_range(2))
        0:       msk = 32'hFF;
        1:       msk = 32'hFFF;
        default: msk = 32'hFFFF;
      endcase
      run("mix", int'($urandom_range(3)), $urandom & 32'hFFFF_0000, msk, $urandom,
          $urandom, int'($urandom_range(1, 20)), 1'b1, int'($urandom_range(30, 100)),
          int'($urandom_range(30, 100)), 0, 0, int'($urandom_range(0, 25)));
    end

    // Zero-length run goes straight to DONE
    @(negedge clk);
    n_trans_i = '0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("zero.done", 64'(done_o), 64'd1);
    check("zero.req", 64'(fetch_req_o), 64'd0);
    check("zero.busy", 64'(busy_o), 64'd0);
    check("zero.issued", 64'(issued_o), 64'd0);

    // Reset with three requests in flight, then a stray response
    mode_i = 2'd0;
    base_addr_i = 32'h2000;
    window_mask_i = 32'hFFF;
    n_trans_i = 32'd8;
    check_en_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    fetch_gnt_i = 1'b1;
    repeat (3) @(negedge clk);
    fetch_gnt_i = 1'b0;
    check("mid.issued", 64'(issued_o), 64'd3);
    rst_n = 1'b0;
    #1;
    check("mid.req", 64'(fetch_req_o), 64'd0);
    check("mid.addr", 64'(fetch_addr_o), 64'd0);
    check("mid.busy", 64'(busy_o), 64'd0);
    check("mid.issued0", 64'(issued_o), 64'd0);
    check("mid.retired0", 64'(retired_o), 64'd0);
    check("mid.proto0", 64'(proto_err_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_rvalid_i = 1'b1;
    fetch_rdata_i = 32'h2000;
    @(negedge clk);
    fetch_rvalid_i = 1'b0;
    check("mid.proto1", 64'(proto_err_o), 64'd1);
    check("mid.retired", 64'(retired_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
